// File: rtl/mult_hazard_unit.sv
// Hazard detection and stall control for a 5-stage pipeline with a multi-cycle EX multiplier.
// It handles load-use stalls, MULT occupancy of EX, and a saturating stall-cycle counter.
module mult_hazard_unit #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       IFID_Rs1,
  input  logic [4:0]       IFID_Rs2,
  input  logic             IFID_UsesRs2,
  input  logic [4:0]       IDEX_Rd,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_IsMult,
  input  logic             flush,
  input  logic             stat_clr,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Bubble,
  output logic             mult_busy,
  output logic             mult_done,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MULT_LAT - 2);

  state_t     state;
  logic [3:0] cnt;
  logic       mult_issue;
  logic       mult_stall;
  logic       load_use;
  logic       rd_match;

  always_comb begin
    rd_match   = (IDEX_Rd == IFID_Rs1) || (IFID_UsesRs2 && (IDEX_Rd == IFID_Rs2));
    mult_issue = (state == IDLE) && IDEX_IsMult && !flush;
    // An illegal MULT+load combination is treated as a MULT, so IsMult masks load-use.
    load_use   = (state == IDLE) && !flush && IDEX_MemRead && !IDEX_IsMult &&
                 (IDEX_Rd != 5'd0) && rd_match;
    mult_stall = mult_issue || ((state == BUSY) && (cnt != 4'd0) && !flush);
    mult_done  = (state == BUSY) && (cnt == 4'd0) && !flush;

    PC_Write     = !(mult_stall || load_use);
    IFID_Write   = !(mult_stall || load_use);
    IDEX_Write   = !mult_stall;
    IDEX_Bubble  = load_use;
    EXMEM_Bubble = mult_stall;
    mult_busy    = (state == BUSY);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_issue) begin
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (flush || (cnt == 4'd0)) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles <= '0;
    end else if (stat_clr) begin
      stall_cycles <= '0;
    end else if (!PC_Write && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: doc/mult_hazard_unit.md
Name: mult_hazard_unit

Overview:
Hazard detection and stall controller for the 5-stage pipeline with a multi-cycle multiplier in EX. The forwarding logic resolves hazards that forwarding can fix. This block covers the cases forwarding cannot fix: it stalls the front end and injects bubbles.
- Covers load-use hazards between the IF/ID instruction and a load in ID/EX.
- Holds the pipeline while a MULT occupies EX for MULT_LAT cycles.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
MULT_LAT, 4, total cycles a MULT spends in EX (legal range 2..15)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  pipeline clock
arst_n  input  1  asynchronous active-low reset
IFID_Rs1  input  5  rs1 of the instruction in IF/ID
IFID_Rs2  input  5  rs2 of the instruction in IF/ID
IFID_UsesRs2  input  1  IF/ID instruction reads rs2 (R-type, store, branch)
IDEX_Rd  input  5  destination register of the instruction in ID/EX
IDEX_MemRead  input  1  ID/EX instruction is a load
IDEX_IsMult  input  1  ID/EX instruction is a MULT
flush  input  1  branch/jump redirect this cycle; aborts a MULT in progress
stat_clr  input  1  synchronous clear of stall_cycles
PC_Write  output  1  0 = hold PC
IFID_Write  output  1  0 = hold IF/ID
IDEX_Write  output  1  0 = hold ID/EX
IDEX_Bubble  output  1  1 = load NOP control into ID/EX
EXMEM_Bubble  output  1  1 = load NOP control into EX/MEM
mult_busy  output  1  FSM in BUSY state (registered)
mult_done  output  1  one-cycle pulse on the final EX cycle of a MULT
stall_cycles  output  CNT_W  saturating count of cycles with PC_Write=0

Behaviour:
FSM states: IDLE, BUSY. Down-counter cnt is 4 bits wide.

Reset (arst_n=0, asynchronous):
- state=IDLE, cnt=0, stall_cycles=0.
- Outputs are driven from state, so PC_Write=IFID_Write=IDEX_Write=1 and both Bubbles=0.
- mult_busy=0, mult_done=0.

Reset mid-MULT: state and counter are discarded; there is no mult_done.

mult_issue = (state==IDLE) && IDEX_IsMult && !flush.

IDLE:
- mult_issue: stall this cycle (see "Stall outputs"); cnt<=MULT_LAT-2; state<=BUSY.
- Otherwise, load-use check:
  - load_use = IDEX_MemRead && !IDEX_IsMult && IDEX_Rd!=0 && (IDEX_Rd==IFID_Rs1 || (IFID_UsesRs2 && IDEX_Rd==IFID_Rs2)).
  - On load_use: PC_Write=0, IFID_Write=0, IDEX_Bubble=1, IDEX_Write=1, EXMEM_Bubble=0.
  - The state does not change. The stall lasts exactly one cycle, because the load then advances.
- IDEX_IsMult && IDEX_MemRead together is illegal; treat it as MULT.

BUSY:
- cnt!=0: stall; cnt<=cnt-1.
- cnt==0: no stall; mult_done=1; state<=IDLE.
- flush=1 in any BUSY cycle:
  - state<=IDLE, no stall that cycle, no mult_done.
  - The flush has priority over everything else in that cycle.

Stall outputs (MULT):
- PC_Write=0, IFID_Write=0, IDEX_Write=0, EXMEM_Bubble=1, IDEX_Bubble=0.
- A MULT therefore produces exactly MULT_LAT-1 stall cycles and then one release cycle, i.e. MULT_LAT cycles in EX.
- The MULT stall overrides load-use: IDEX holds a MULT, so a load-use hazard cannot coexist with it.

Back-to-back MULTs: the cycle after release, the state is IDLE again. A new MULT in ID/EX issues immediately, with no idle gap.

flush in IDLE: suppresses mult_issue and load_use stalls, so all outputs take their pass-through values.

Zero register: IDEX_Rd==0 never causes a load-use stall.

mult_done: combinational from state==BUSY && cnt==0 && !flush.

stall_cycles:
- Increments when PC_Write==0.
- Saturates at all-ones; there is no wrap-around.
- stat_clr has priority and sets it to 0. If stat_clr and a stall occur in the same cycle, the result is 0.

Combinational outputs carry no added latency. State, cnt and stall_cycles update on the rising edge of clk.

Test Plan:
1. Reset then idle, with all inputs 0 → PC_Write=IFID_Write=IDEX_Write=1, Bubbles=0, stall_cycles=0.
2. Load-use:
   - IDEX_MemRead=1, IDEX_Rd=5, IFID_Rs1=5 → exactly one cycle of PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
   - Repeat with IDEX_Rd=0 → no stall.
   - IFID_Rs2=5 with IFID_UsesRs2=0 → no stall.
3. MULT with MULT_LAT=4: IDEX_IsMult held 4 cycles from issue →
   - Stall and EXMEM_Bubble=1 on cycles 0–2.
   - mult_done=1 with no stall on cycle 3.
   - mult_busy=1 on cycles 1–3.
   - stall_cycles=3.
4. Back-to-back MULTs (IsMult held 8 cycles) → stall pattern 1,1,1,0,1,1,1,0; mult_done on cycles 3 and 7; stall_cycles=6.
5. Abort:
   - flush=1 in BUSY cycle 2 → no stall that cycle, no mult_done, state=IDLE next cycle.
   - arst_n pulsed low in BUSY → immediate IDLE, all outputs at reset values.
6. Counter: CNT_W=4 with 20 stall cycles → stall_cycles saturates at 15. stat_clr concurrent with a stall → 0.
